mrelbp_ci_frame: RTL

- Parametrised next-generation MRELBP centre-intensity (CI) block. Generalises the fixed 17-sample, 8-bit R8 CI stage in sample count, pixel width, frame size and compare mode.
- Accumulates the selected centre sample over one full frame and stores each centre value in an internal buffer.
- Computes the frame mean with a sequential divider, then replays the buffer and emits one CI bit per pixel.
- Sits after the median-filter window stage and in front of the MRELBP histogram/concatenation logic.

---
 rtl/mrelbp_ci_frame.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mrelbp_ci_frame.sv
// MRELBP centre-intensity stage: buffers one frame of centre samples, divides the
// frame sum by the pixel count, then replays the buffer emitting one CI bit per pixel.
module mrelbp_ci_frame #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_S      = 17,
   parameter int unsigned CENTER_IDX = 0,
   parameter int unsigned IMG_W      = 8,
   parameter int unsigned IMG_H      = 8,
   parameter int unsigned CMP_MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    done_i,
   input  logic [NUM_S*DATA_W-1:0] s_i,
   output logic                    done_o,
   output logic                    ci_o,
   output logic                    progress_done_o,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam int unsigned N_PIX = IMG_W * IMG_H;
   localparam int unsigned CNT_W = $clog2(N_PIX);
   localparam int unsigned AW    = (CNT_W > 0) ? CNT_W : 1;
   localparam int unsigned SUM_W = DATA_W + CNT_W;
   localparam int unsigned RW    = CNT_W + 1;
   localparam int unsigned DC_W  = $clog2(SUM_W + 1);
   localparam logic [AW-1:0] LAST = AW'(N_PIX - 1);

   typedef enum logic [2:0] {IDLE, ACCUM, DIVIDE, PRIME, EMIT, FINISH} state_t;

   state_t state, state_nx;

   logic [SUM_W-1:0]  sum, sum_nx, dq;
   logic [AW-1:0]     count, wr_addr, rd_addr;
   logic [RW-1:0]     rem, rem_sh, rem_nx;
   logic [DC_W-1:0]   dcnt;
   logic [DATA_W-1:0] centre, rd_data, mean;
   logic [DATA_W-1:0] mem [N_PIX];
   logic              accept, last_pix, div_last, ge, rd_en, cmp;

   assign centre   = s_i[CENTER_IDX*DATA_W +: DATA_W];
   assign busy_o   = (state == DIVIDE) || (state == PRIME) || (state == EMIT) || (state == FINISH);
   assign accept   = done_i && !busy_o;
   assign last_pix = (state == IDLE) ? (N_PIX == 1) : (count == LAST);
   assign wr_addr  = (state == IDLE) ? '0 : count;
   assign sum_nx   = ((state == IDLE) ? '0 : sum) + SUM_W'(centre);
   assign div_last = (dcnt == DC_W'(SUM_W - 1));

   // Remainder never reaches N_PIX, so dropping its MSB on the shift loses nothing.
   assign rem_sh = RW'({rem, dq[SUM_W-1]});
   assign ge     = (rem_sh >= RW'(N_PIX));
   assign rem_nx = ge ? (rem_sh - RW'(N_PIX)) : rem_sh;

   assign mean    = dq[DATA_W-1:0];
   assign cmp     = (CMP_MODE == 0) ? (rd_data >= mean) : (rd_data > mean);
   assign rd_en   = (state == PRIME) || ((state == EMIT) && (count != LAST));
   assign rd_addr = (state == PRIME) ? '0 : count + AW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = last_pix ? DIVIDE : ACCUM;
         ACCUM:   if (accept && last_pix) state_nx = DIVIDE;
         DIVIDE:  if (div_last) state_nx = PRIME;
         PRIME:   state_nx = EMIT;
         EMIT:    if (count == LAST) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum             <= '0;
         count           <= '0;
         dq              <= '0;
         rem             <= '0;
         dcnt            <= '0;
         done_o          <= 1'b0;
         ci_o            <= 1'b0;
         progress_done_o <= 1'b0;
         err_o           <= 1'b0;
      end else begin
         done_o          <= (state == EMIT);
         ci_o            <= (state == EMIT) && cmp;
         progress_done_o <= (state == FINISH);
         if (done_i && busy_o) err_o <= 1'b1;
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  sum   <= sum_nx;
                  count <= wr_addr + AW'(1);
                  if (last_pix) begin
                     dq   <= sum_nx;
                     rem  <= '0;
                     dcnt <= '0;
                  end
               end
            end
            DIVIDE: begin
               dq   <= SUM_W'({dq, ge});
               rem  <= rem_nx;
               dcnt <= dcnt + DC_W'(1);
            end
            PRIME:   count <= '0;
            EMIT:    count <= count + AW'(1);
            default: ;
         endcase
      end
   end

   // Frame buffer carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_addr] <= centre;
      if (rd_en)  rd_data      <= mem[rd_addr];
   end

endmodule
